// File: rtl/fetch_unit_if.sv
// ---------------------------------------------------------------------------
// fetch_unit_if : PC, instruction-memory, redirect and decode-side signals
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface fetch_unit_if;
  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;

  modport master (
    input  pc_cur,
    output pc_next,
    output imem_req_valid,
    input  imem_req_ready,
    output imem_addr,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  redirect_valid,
    input  redirect_pc,
    output if_valid,
    input  if_ready,
    output if_instr,
    output if_pc,
    output fetch_fault
  );

  modport slave (
    output pc_cur,
    input  pc_next,
    input  imem_req_valid,
    output imem_req_ready,
    input  imem_addr,
    output imem_rsp_valid,
    output imem_rsp_data,
    output redirect_valid,
    output redirect_pc,
    input  if_valid,
    output if_ready,
    input  if_instr,
    input  if_pc,
    input  fetch_fault
  );
endinterface

`default_nettype wire

// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit : single-outstanding instruction fetch sequencer feeding decode.
// Optional FETCH_ALIGN_CHECK_EN: misaligned redirect raises sticky fetch_fault.
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  wire logic    clk,
  input  wire logic    rst,
  fetch_unit_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_OUT  = 2'd3;

  logic [1:0]  state_q, state_d;
  logic        drop_q, drop_d;
  logic        fault_q, fault_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic [31:0] if_instr_q, if_instr_d;
  logic [31:0] if_pc_q, if_pc_d;

  logic        req_accept;
  logic        redir_go;
  logic        redir_bad;
  logic [31:0] redir_target;

  assign req_accept = (state_q == S_REQ) && bus.imem_req_ready;
  assign redir_go   = (state_q != S_IDLE) && bus.redirect_valid;

`ifdef FETCH_ALIGN_CHECK_EN
  assign redir_target = bus.redirect_pc;
  assign redir_bad    = redir_go && (bus.redirect_pc[1:0] != 2'b00);
`else
  assign redir_target = {bus.redirect_pc[31:2], 2'b00};
  assign redir_bad    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      drop_q     <= 1'b0;
      fault_q    <= 1'b0;
      req_pc_q   <= 32'h0;
      if_instr_q <= 32'h0;
      if_pc_q    <= 32'h0;
    end else begin
      state_q    <= state_d;
      drop_q     <= drop_d;
      fault_q    <= fault_d;
      req_pc_q   <= req_pc_d;
      if_instr_q <= if_instr_d;
      if_pc_q    <= if_pc_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    drop_d     = drop_q;
    fault_d    = fault_q;
    req_pc_d   = req_pc_q;
    if_instr_d = if_instr_q;
    if_pc_d    = if_pc_q;
    case (state_q)
      S_IDLE: begin
        // A latched fault parks the sequencer here until reset.
        if (!fault_q) state_d = S_REQ;
      end
      S_REQ: begin
        if (req_accept) begin
          req_pc_d = bus.pc_cur;
          state_d  = S_WAIT;
          if (bus.redirect_valid) drop_d = 1'b1;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          if (drop_q || bus.redirect_valid) begin
            drop_d  = 1'b0;
            state_d = S_REQ;
          end else begin
            if_instr_d = bus.imem_rsp_data;
            if_pc_d    = req_pc_q;
            state_d    = S_OUT;
          end
        end else if (bus.redirect_valid) begin
          drop_d = 1'b1;
        end
      end
      default: begin
        if (bus.redirect_valid || bus.if_ready) state_d = S_REQ;
      end
    endcase
    if (redir_bad) begin
      state_d = S_IDLE;
      drop_d  = 1'b0;
      fault_d = 1'b1;
    end
  end

  always_comb begin
    bus.imem_req_valid = (state_q == S_REQ);
    bus.imem_addr      = bus.pc_cur;
    bus.if_valid       = (state_q == S_OUT);
    bus.if_instr       = if_instr_q;
    bus.if_pc          = if_pc_q;
    bus.fetch_fault    = fault_q;
    // The PC register loads pc_next every clock, so reset must steer it too.
    if (!rst)            bus.pc_next = RESET_PC;
    else if (redir_go)   bus.pc_next = redir_target;
    else if (req_accept) bus.pc_next = bus.pc_cur + PC_STEP;
    else                 bus.pc_next = bus.pc_cur;
  end

endmodule

`default_nettype wire
